// File: rtl/ring_osc_trim_cal.sv
// Closed-loop trim calibration for a ring oscillator. The block counts oscillator edges over a
// window and steps a thermometer trim code until the count lands within a tolerance band.
module ring_osc_trim_cal #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MAX_ITER      = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        osc_in_i,
    input  logic [15:0] window_cycles_i,
    input  logic [15:0] target_count_i,
    input  logic [7:0]  tolerance_i,
    output logic [25:0] trim_o,
    output logic [4:0]  trim_code_o,
    output logic        osc_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic [15:0] meas_count_o
);

    localparam logic [4:0] CodeMax = 5'd26;

    typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StCompare, StDone} state_e;

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               osc_prev_q;
    logic [31:0]        phase_q, phase_d;
    logic [15:0]        edge_cnt_q, edge_cnt_d;
    logic [31:0]        iter_q, iter_d;
    logic [4:0]         code_q, code_d;
    logic [25:0]        trim_q, trim_d;
    logic [15:0]        meas_q, meas_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic               osc_reset_q, osc_reset_d;

    logic               osc_rise;
    logic [16:0]        lim_hi, lim_lo, cnt_ext;
    logic               too_fast, too_slow, last_iter;

    // Rising edge is detected on the final synchronizer stage against its own previous value.
    assign osc_rise = sync_q[SYNC_STAGES-1] & ~osc_prev_q;

    assign lim_hi    = {1'b0, target_count_i} + {9'd0, tolerance_i};
    assign lim_lo    = (target_count_i >= {8'd0, tolerance_i}) ?
                       {1'b0, target_count_i - {8'd0, tolerance_i}} : 17'd0;
    assign cnt_ext   = {1'b0, edge_cnt_q};
    assign too_fast  = cnt_ext > lim_hi;
    assign too_slow  = cnt_ext < lim_lo;
    assign last_iter = (iter_q == 32'(MAX_ITER - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            sync_q      <= '0;
            osc_prev_q  <= 1'b0;
            phase_q     <= '0;
            edge_cnt_q  <= '0;
            iter_q      <= '0;
            code_q      <= '0;
            trim_q      <= '0;
            meas_q      <= '0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            osc_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], osc_in_i};
            osc_prev_q  <= sync_q[SYNC_STAGES-1];
            phase_q     <= phase_d;
            edge_cnt_q  <= edge_cnt_d;
            iter_q      <= iter_d;
            code_q      <= code_d;
            trim_q      <= trim_d;
            meas_q      <= meas_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            osc_reset_q <= osc_reset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        edge_cnt_d  = edge_cnt_q;
        iter_d      = iter_q;
        code_d      = code_q;
        meas_d      = meas_q;
        locked_d    = locked_q;
        fail_d      = fail_q;
        osc_reset_d = osc_reset_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    osc_reset_d = 1'b0;
                    locked_d    = 1'b0;
                    fail_d      = 1'b0;
                    iter_d      = '0;
                    phase_d     = '0;
                    if (window_cycles_i == 16'd0) begin
                        fail_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                if (phase_q == 32'(SETTLE_CYCLES - 1)) begin
                    phase_d    = '0;
                    edge_cnt_d = '0;
                    state_d    = StMeasure;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            StMeasure: begin
                if (osc_rise && (edge_cnt_q != 16'hFFFF)) begin
                    edge_cnt_d = edge_cnt_q + 16'd1;
                end
                if (phase_q == ({16'd0, window_cycles_i} - 32'd1)) begin
                    phase_d = '0;
                    state_d = StCompare;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            StCompare: begin
                meas_d = edge_cnt_q;
                iter_d = iter_q + 32'd1;
                if (!too_fast && !too_slow) begin
                    locked_d = 1'b1;
                    state_d  = StDone;
                end else if (last_iter || (too_fast && code_q == CodeMax) ||
                             (too_slow && code_q == 5'd0)) begin
                    fail_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    // A high count means the oscillator runs fast, so more trim slows it down.
                    code_d  = too_fast ? code_q + 5'd1 : code_q - 5'd1;
                    state_d = StSettle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        trim_d = '0;
        for (int i = 0; i < 26; i++) begin
            trim_d[i] = (code_d > 5'(i));
        end
    end

    assign trim_o       = trim_q;
    assign trim_code_o  = code_q;
    assign osc_reset_o  = osc_reset_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign meas_count_o = meas_q;

endmodule
